// File: rtl/pc_branch_unit_pkg.sv
// pc_branch_unit_pkg: shared FSM encodings, instruction-class indices and default vectors
package pc_branch_unit_pkg;
    typedef enum logic [1:0] {RUN = 2'd0, FLUSH1 = 2'd1, FLUSH2 = 2'd2} state_e;
    localparam int CLS_BRANCH = 0;
    localparam int CLS_JAL = 1;
    localparam int CLS_JALR = 2;
    localparam int CLS_W = 3;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;
    localparam logic [63:0] DEFAULT_TRAP_VECTOR = 64'h100;
endpackage

// File: rtl/pc_branch_unit_if.sv
// pc_branch_unit_if: EX-stage control-flow inputs and fetch-side outputs
interface pc_branch_unit_if;
    logic ex_valid;
    logic ex_is_branch;
    logic ex_is_jal;
    logic ex_is_jalr;
    logic [63:0] ex_pc;
    logic [63:0] ex_imm;
    logic [63:0] alu_result;
    logic alu_zero;
    logic stall;
    logic [63:0] pc;
    logic flush;
    logic misalign;
    logic [31:0] taken_cnt;
    modport master (
        output ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, ex_pc, ex_imm, alu_result, alu_zero, stall,
        input pc, flush, misalign, taken_cnt
    );
    modport slave (
        input ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, ex_pc, ex_imm, alu_result, alu_zero, stall,
        output pc, flush, misalign, taken_cnt
    );
endinterface

// File: rtl/pc_branch_unit_next_pc_sel.sv
// next_pc_sel: redirect target, alignment check and next-PC selection
module next_pc_sel
    import pc_branch_unit_pkg::*;
#(
    parameter logic [63:0] TRAP_VECTOR = DEFAULT_TRAP_VECTOR
) (
    input  logic [63:0] pc,
    input  logic [63:0] ex_pc,
    input  logic [63:0] ex_imm,
    input  logic [63:0] alu_result,
    input  logic        is_jalr,
    input  logic        redirect,
    input  logic        stall,
    output logic [63:0] next_pc,
    output logic        target_misaligned
);
    logic [63:0] target;
    always_comb begin
        target = is_jalr ? {alu_result[63:1], 1'b0} : ex_pc + ex_imm;
        target_misaligned = target[1:0] != 2'b00;
        next_pc = redirect ? (target_misaligned ? TRAP_VECTOR : target) : stall ? pc : pc + 64'd4;
    end
endmodule

// File: rtl/pc_branch_unit.sv
// pc_branch_unit: not-taken fetch PC with EX redirect, two-cycle flush FSM, misalign flag and taken counter
module pc_branch_unit
    import pc_branch_unit_pkg::*;
#(
    parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [63:0] TRAP_VECTOR = DEFAULT_TRAP_VECTOR
) (
    input logic clk,
    input logic reset,
    pc_branch_unit_if.slave bus
);
    state_e state_q, state_d;
    logic [63:0] pc_q, pc_d, next_pc;
    logic flush_q, flush_d, misalign_q, misalign_d;
    logic [31:0] taken_cnt_q, taken_cnt_d;
    logic [CLS_W-1:0] cls;
    logic redirect, target_misaligned;
    // cls holds only the classes that actually redirect this cycle
    always_comb begin
        cls = '0;
        cls[CLS_BRANCH] = bus.ex_is_branch & bus.alu_zero;
        cls[CLS_JAL] = bus.ex_is_jal;
        cls[CLS_JALR] = bus.ex_is_jalr;
        redirect = bus.ex_valid && state_q == RUN && |cls;
    end
    next_pc_sel #(.TRAP_VECTOR(TRAP_VECTOR)) u_sel (
        .pc(pc_q),
        .ex_pc(bus.ex_pc),
        .ex_imm(bus.ex_imm),
        .alu_result(bus.alu_result),
        .is_jalr(cls[CLS_JALR]),
        .redirect(redirect),
        .stall(bus.stall),
        .next_pc(next_pc),
        .target_misaligned(target_misaligned)
    );
    always_comb begin
        state_d = redirect ? FLUSH1 : state_q == FLUSH1 ? FLUSH2 : RUN;
        flush_d = state_d != RUN;
        pc_d = next_pc;
        misalign_d = misalign_q | (redirect & target_misaligned);
        taken_cnt_d = taken_cnt_q + 32'(redirect);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            pc_q <= RESET_PC;
            flush_q <= 1'b0;
            misalign_q <= 1'b0;
            taken_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q <= pc_d;
            flush_q <= flush_d;
            misalign_q <= misalign_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end
    assign bus.pc = pc_q;
    assign bus.flush = flush_q;
    assign bus.misalign = misalign_q;
    assign bus.taken_cnt = taken_cnt_q;
endmodule

// File: tb/tb_pc_branch_unit.sv
// tb_pc_branch_unit: directed vectors checked against a cycle model and literal expectations
module tb_pc_branch_unit;
    logic clk, reset;
    pc_branch_unit_if bus();
    pc_branch_unit dut (.clk(clk), .reset(reset), .bus(bus));

    int errors = 0, checks = 0;
    bit chk_en = 0;
    logic [63:0] m_pc, tgt;
    logic [31:0] m_cnt;
    logic m_mis;
    int m_fl;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // model: redirects allowed only when no flush cycles remain
    always @(posedge clk) begin
        if (reset) begin
            m_pc = 64'h0; m_cnt = 0; m_mis = 0; m_fl = 0;
        end else if (bus.ex_valid && m_fl == 0 &&
                     (bus.ex_is_jal || bus.ex_is_jalr || (bus.ex_is_branch && bus.alu_zero))) begin
            tgt = bus.ex_is_jalr ? (bus.alu_result & ~64'd1) : bus.ex_pc + bus.ex_imm;
            if (tgt % 4 != 0) begin
                m_pc = 64'h100; m_mis = 1;
            end else m_pc = tgt;
            m_cnt = m_cnt + 1;
            m_fl = 2;
        end else begin
            if (m_fl > 0) m_fl = m_fl - 1;
            if (!bus.stall) m_pc = m_pc + 4;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checks += 4;
            if (bus.pc !== m_pc) begin errors++; $display("FAIL model_pc got=%h exp=%h t=%0t", bus.pc, m_pc, $time); end
            if (bus.flush !== (m_fl != 0)) begin errors++; $display("FAIL model_flush got=%b exp=%b t=%0t", bus.flush, m_fl != 0, $time); end
            if (bus.misalign !== m_mis) begin errors++; $display("FAIL model_misalign got=%b exp=%b t=%0t", bus.misalign, m_mis, $time); end
            if (bus.taken_cnt !== m_cnt) begin errors++; $display("FAIL model_cnt got=%0d exp=%0d t=%0t", bus.taken_cnt, m_cnt, $time); end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic drv(input logic v, br, j, jr, input logic [63:0] epc, imm, alu, input logic az, st);
        bus.ex_valid = v; bus.ex_is_branch = br; bus.ex_is_jal = j; bus.ex_is_jalr = jr;
        bus.ex_pc = epc; bus.ex_imm = imm; bus.alu_result = alu; bus.alu_zero = az; bus.stall = st;
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1;
        chk("rst_pc", bus.pc, 0);
        chk("rst_flush", 64'(bus.flush), 0);
        chk("rst_cnt", 64'(bus.taken_cnt), 0);
        reset = 0;
        step(); chk("idle_pc1", bus.pc, 64'h4);
        step(); chk("idle_pc2", bus.pc, 64'h8);
        step(); chk("idle_pc3", bus.pc, 64'hc);
        chk("idle_flush", 64'(bus.flush), 0);
        drv(1, 1, 0, 0, 64'h20, 64'h40, 0, 1, 0);
        step(); chk("br_pc", bus.pc, 64'h60); chk("br_flush1", 64'(bus.flush), 1); chk("br_cnt", 64'(bus.taken_cnt), 1);
        idle();
        step(); chk("br_flush2", 64'(bus.flush), 1); chk("br_pc2", bus.pc, 64'h64);
        step(); chk("br_flush_end", 64'(bus.flush), 0); chk("br_pc3", bus.pc, 64'h68);
        drv(1, 1, 0, 0, 64'h20, 64'h40, 0, 0, 0);
        step(); chk("nt_pc", bus.pc, 64'h6c); chk("nt_flush", 64'(bus.flush), 0); chk("nt_cnt", 64'(bus.taken_cnt), 1);
        drv(1, 0, 0, 1, 0, 0, 64'h1003, 0, 0);
        step(); chk("jalr_trap_pc", bus.pc, 64'h100); chk("jalr_mis", 64'(bus.misalign), 1); chk("jalr_cnt", 64'(bus.taken_cnt), 2);
        idle(); step(); step();
        drv(1, 0, 0, 1, 0, 0, 64'h2001, 0, 0);
        step(); chk("jalr_al_pc", bus.pc, 64'h2000); chk("mis_sticky", 64'(bus.misalign), 1);
        idle(); step(); step();
        drv(1, 0, 1, 0, 64'h300, 64'h10, 0, 0, 1);
        step(); chk("jal_stall_pc", bus.pc, 64'h310);
        drv(1, 0, 1, 0, 64'h500, 64'h8, 0, 0, 0);
        step(); chk("jal2_ign_pc", bus.pc, 64'h314); chk("jal2_ign_cnt", 64'(bus.taken_cnt), 4);
        idle();
        step(); chk("post_pc", bus.pc, 64'h318);
        bus.stall = 1;
        step(); chk("stall_hold", bus.pc, 64'h318);
        drv(1, 1, 1, 1, 64'h10, 64'h20, 64'h4000, 0, 0);
        step(); chk("prio_jalr", bus.pc, 64'h4000);
        idle(); step(); step();
        drv(1, 1, 1, 0, 64'h50, 64'h30, 0, 0, 0);
        step(); chk("prio_jal", bus.pc, 64'h80);
        idle(); step(); step();
        drv(1, 0, 1, 0, 64'h8, 64'hFFFF_FFFF_FFFF_FFF0, 0, 0, 0);
        step(); chk("wrap_pc", bus.pc, 64'hFFFF_FFFF_FFFF_FFF8);
        idle(); step(); step();
        drv(1, 0, 1, 0, 64'h20, 64'h2, 0, 0, 0);
        step(); chk("jal_mis_pc", bus.pc, 64'h100); chk("cnt8", 64'(bus.taken_cnt), 8);
        idle(); step(); step();
        drv(1, 0, 1, 0, 64'h40, 64'h40, 0, 0, 0);
        step(); chk("pre_rst_flush", 64'(bus.flush), 1);
        reset = 1;
        step(); chk("rst_f1_pc", bus.pc, 0); chk("rst_f1_flush", 64'(bus.flush), 0);
        chk("rst_f1_cnt", 64'(bus.taken_cnt), 0); chk("rst_f1_mis", 64'(bus.misalign), 0);
        reset = 0; idle();
        step(); chk("after_rst_pc", bus.pc, 64'h4); chk("after_rst_flush", 64'(bus.flush), 0);
        drv(1, 1, 0, 0, 64'h8, 64'h8, 0, 1, 0);
        step(); chk("run_again", bus.pc, 64'h10);
        idle(); step(); step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
